// File: rtl/dcache_pkg.sv
// dcache_pkg
//   Shared definitions for the direct-mapped, write-back data cache.
//   - Default geometry: 8-bit byte address, 8-bit data, 8 lines of 4-byte blocks.
//   - Controller state encoding.
//   - Helpers that split a cpu byte address into {tag, index, offset}.
package dcache_pkg;

    localparam int CPU_ADDR_W = 8;
    localparam int CPU_DATA_W = 8;
    localparam int INDEX_W    = 3;
    localparam int OFFSET_W   = 2;
    localparam int TAG_W      = CPU_ADDR_W - INDEX_W - OFFSET_W;
    localparam int BLOCK_W    = CPU_DATA_W << OFFSET_W;
    localparam int LINES      = 1 << INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WRITE_BACK = 2'd1,
        S_MEM_READ   = 2'd2,
        S_UPDATE     = 2'd3
    } dcache_state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [CPU_ADDR_W-1:0] addr);
        return addr[CPU_ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [CPU_ADDR_W-1:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [CPU_ADDR_W-1:0] addr);
        return addr[OFFSET_W-1:0];
    endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array
//   Per-line storage of the cache: valid, dirty, tag and block data.
//   Ports:
//     clk, rst_n       clock, asynchronous active-low reset (clears valid/dirty only)
//     index            line selected for both read and write
//     line_valid/line_dirty/line_tag/line_data   combinational view of that line
//     byte_we, byte_off, byte_data   store one byte into the line and mark it dirty
//     blk_we, blk_tag, blk_data      install a whole block: valid=1, dirty=0
module dcache_array
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS  = INDEX_W,
    parameter int OFFSET_BITS = OFFSET_W,
    parameter int TAG_BITS    = TAG_W,
    parameter int DATA_W      = CPU_DATA_W,
    localparam int BLK_BITS   = DATA_W << OFFSET_BITS,
    localparam int NLINES     = 1 << INDEX_BITS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INDEX_BITS-1:0]  index,
    output logic                   line_valid,
    output logic                   line_dirty,
    output logic [TAG_BITS-1:0]    line_tag,
    output logic [BLK_BITS-1:0]    line_data,
    input  logic                   byte_we,
    input  logic [OFFSET_BITS-1:0] byte_off,
    input  logic [DATA_W-1:0]      byte_data,
    input  logic                   blk_we,
    input  logic [TAG_BITS-1:0]    blk_tag,
    input  logic [BLK_BITS-1:0]    blk_data
);

    logic [NLINES-1:0]   valid_q;
    logic [NLINES-1:0]   dirty_q;
    logic [TAG_BITS-1:0] tag_mem  [NLINES];
    logic [BLK_BITS-1:0] data_mem [NLINES];

    assign line_valid = valid_q[index];
    assign line_dirty = dirty_q[index];
    assign line_tag   = tag_mem[index];
    assign line_data  = data_mem[index];

    // Status bits are the only state that reset touches; stale tags and
    // data are harmless once valid is clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (blk_we) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (byte_we) begin
            dirty_q[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (blk_we) begin
            tag_mem[index]  <= blk_tag;
            data_mem[index] <= blk_data;
        end else if (byte_we) begin
            data_mem[index][32'(byte_off) * DATA_W +: DATA_W] <= byte_data;
        end
    end

endmodule

// File: rtl/data_cache.sv
// data_cache
//   Direct-mapped, write-back, write-allocate data cache between the cpu
//   data port and a block-wide main memory.
//   Ports:
//     CLK, RESET                       clock, asynchronous active-low reset
//     READ, WRITE, ADDRESS, WRITEDATA  cpu request (held stable while BUSYWAIT=1)
//     READDATA, BUSYWAIT               cpu load data and stall
//     MEM_READ, MEM_WRITE              memory block read / write request
//     MEM_ADDRESS                      block address {tag,index}
//     MEM_WRITEDATA, MEM_READDATA      block data, byte0 in [7:0]
//     MEM_BUSYWAIT                     memory busy
//
// Handshake: a memory request is held high, with constant address/data,
// until a posedge at which MEM_BUSYWAIT is low; that edge completes the
// transfer. On the cpu side, an access completes at the first posedge where
// BUSYWAIT is low; until then the cpu keeps its request steady.
module data_cache
    import dcache_pkg::*;
#(
    parameter int ADDR_W      = CPU_ADDR_W,
    parameter int DATA_W      = CPU_DATA_W,
    parameter int INDEX_BITS  = INDEX_W,
    parameter int OFFSET_BITS = OFFSET_W,
    localparam int TAG_BITS   = ADDR_W - INDEX_BITS - OFFSET_BITS,
    localparam int BLK_BITS   = DATA_W << OFFSET_BITS
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          READ,
    input  logic                          WRITE,
    input  logic [ADDR_W-1:0]             ADDRESS,
    input  logic [DATA_W-1:0]             WRITEDATA,
    output logic [DATA_W-1:0]             READDATA,
    output logic                          BUSYWAIT,
    output logic                          MEM_READ,
    output logic                          MEM_WRITE,
    output logic [ADDR_W-OFFSET_BITS-1:0] MEM_ADDRESS,
    output logic [BLK_BITS-1:0]           MEM_WRITEDATA,
    input  logic [BLK_BITS-1:0]           MEM_READDATA,
    input  logic                          MEM_BUSYWAIT
);

    dcache_state_t state, next_state;

    logic [TAG_BITS-1:0]    req_tag;
    logic [INDEX_BITS-1:0]  req_index;
    logic [OFFSET_BITS-1:0] req_offset;

    logic                   line_valid;
    logic                   line_dirty;
    logic [TAG_BITS-1:0]    line_tag;
    logic [BLK_BITS-1:0]    line_data;

    logic                   req;
    logic                   is_read;
    logic                   hit;

    logic [BLK_BITS-1:0]    fill_q;

    logic                   busy;
    logic                   mem_rd;
    logic                   mem_wr;
    logic [ADDR_W-OFFSET_BITS-1:0] mem_addr;
    logic [BLK_BITS-1:0]    mem_wdata;
    logic [DATA_W-1:0]      rdata;
    logic                   byte_we;
    logic                   blk_we;

    assign req_tag    = ADDRESS[ADDR_W-1 -: TAG_BITS];
    assign req_index  = ADDRESS[OFFSET_BITS +: INDEX_BITS];
    assign req_offset = ADDRESS[OFFSET_BITS-1:0];

    assign req     = READ | WRITE;
    // READ wins when both are raised: the access never modifies the array.
    assign is_read = READ;
    assign hit     = line_valid && (line_tag == req_tag);

    dcache_array #(
        .INDEX_BITS  (INDEX_BITS),
        .OFFSET_BITS (OFFSET_BITS),
        .TAG_BITS    (TAG_BITS),
        .DATA_W      (DATA_W)
    ) u_array (
        .clk        (CLK),
        .rst_n      (RESET),
        .index      (req_index),
        .line_valid (line_valid),
        .line_dirty (line_dirty),
        .line_tag   (line_tag),
        .line_data  (line_data),
        .byte_we    (byte_we),
        .byte_off   (req_offset),
        .byte_data  (WRITEDATA),
        .blk_we     (blk_we),
        .blk_tag    (req_tag),
        .blk_data   (fill_q)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The fetched block is parked here for the single UPDATE cycle, so the
    // array write does not depend on memory holding MEM_READDATA.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            fill_q <= '0;
        end else if (state == S_MEM_READ && !MEM_BUSYWAIT) begin
            fill_q <= MEM_READDATA;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        rdata      = '0;
        byte_we    = 1'b0;
        blk_we     = 1'b0;

        case (state)
            S_IDLE: begin
                if (req) begin
                    if (hit) begin
                        if (is_read) begin
                            rdata = line_data[32'(req_offset) * DATA_W +: DATA_W];
                        end else begin
                            byte_we = 1'b1;
                        end
                    end else begin
                        busy       = 1'b1;
                        next_state = (line_valid && line_dirty) ? S_WRITE_BACK : S_MEM_READ;
                    end
                end
            end
            S_WRITE_BACK: begin
                busy      = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = {line_tag, req_index};
                mem_wdata = line_data;
                if (!MEM_BUSYWAIT) begin
                    next_state = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                busy     = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = ADDRESS[ADDR_W-1:OFFSET_BITS];
                if (!MEM_BUSYWAIT) begin
                    next_state = S_UPDATE;
                end
            end
            S_UPDATE: begin
                busy       = 1'b1;
                blk_we     = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // While RESET is low every output is forced quiet, even if the cpu is
    // still presenting a request that would otherwise report a miss.
    assign BUSYWAIT      = RESET & busy;
    assign MEM_READ      = RESET & mem_rd;
    assign MEM_WRITE     = RESET & mem_wr;
    assign MEM_ADDRESS   = RESET ? mem_addr  : '0;
    assign MEM_WRITEDATA = RESET ? mem_wdata : '0;
    assign READDATA      = RESET ? rdata     : '0;

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

  logic        clk;
  logic        rst_n;
  logic        rd;
  logic        wr;
  logic [7:0]  addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        busy;
  logic        mem_rd;
  logic        mem_wr;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_busy;

  int total;
  int bad;
  int lat;
  int cnt;
  int overlap;

  logic [5:0]  rd_log_q[$];
  logic [5:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  data_cache dut (
    .CLK           (clk),
    .RESET         (rst_n),
    .READ          (rd),
    .WRITE         (wr),
    .ADDRESS       (addr),
    .WRITEDATA     (wdata),
    .READDATA      (rdata),
    .BUSYWAIT      (busy),
    .MEM_READ      (mem_rd),
    .MEM_WRITE     (mem_wr),
    .MEM_ADDRESS   (mem_addr),
    .MEM_WRITEDATA (mem_wdata),
    .MEM_READDATA  (mem_rdata),
    .MEM_BUSYWAIT  (mem_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: busy for lat cycles after a request appears, then done
  function automatic logic [31:0] block_of(input logic [5:0] a);
    case (a)
      6'h00:   return 32'h03020100;
      6'h04:   return 32'h13121110;
      6'h09:   return 32'hDDCCBBAA;
      6'h10:   return 32'h88776655;
      6'h21:   return 32'hA3A2A1A0;
      6'h29:   return 32'h44332211;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  assign mem_rdata = block_of(mem_addr);
  assign mem_busy  = (mem_rd | mem_wr) && (cnt < lat);

  always @(posedge clk) begin
    if ((mem_rd | mem_wr) && !mem_busy) begin
      cnt <= 0;
      if (mem_rd) rd_log_q.push_back(mem_addr);
      if (mem_wr) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_wdata);
      end
    end else if (mem_rd | mem_wr) begin
      cnt <= cnt + 1;
    end else begin
      cnt <= 0;
    end
  end

  always @(negedge clk) begin
    if (mem_rd && mem_wr) overlap = overlap + 1;
  end

  // scoreboard helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_rd_log(input string name, input logic [5:0] exp);
    logic [5:0] a;
    a = 6'h3F;
    if (rd_log_q.size() != 0) a = rd_log_q.pop_front();
    check(name, {26'd0, a}, {26'd0, exp});
  endtask

  task automatic check_wr_log(input string name, input logic [5:0] exp_a, input logic [31:0] exp_d);
    logic [5:0]  a;
    logic [31:0] d;
    a = 6'h3F;
    d = 32'hFFFFFFFF;
    if (wr_addr_q.size() != 0) begin
      a = wr_addr_q.pop_front();
      d = wr_data_q.pop_front();
    end
    check({name, "_addr"}, {26'd0, a}, {26'd0, exp_a});
    check({name, "_data"}, d, exp_d);
  endtask

  // driver: present a request and wait (bounded) for the hit cycle
  task automatic access(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d,
                        output int stalls, output logic [7:0] data);
    rd = r;
    wr = w;
    addr = a;
    wdata = d;
    stalls = 0;
    data = 8'h00;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        data = rdata;
        break;
      end
      stalls = stalls + 1;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    rd = 1'b0;
    wr = 1'b0;
  endtask

  typedef struct {
    logic       r;
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    logic       exp_busy;
    logic       chk_data;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[9];

  int         st;
  logic [7:0] got;

  initial begin
    total = 0;
    bad = 0;
    overlap = 0;
    lat = 5;
    cnt = 0;
    rst_n = 1'b0;
    rd = 1'b1;
    wr = 1'b0;
    addr = 8'h10;
    wdata = 8'h00;

    // reset state, with a request pending that must not show a stall
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busywait", {31'd0, busy}, 32'd0);
    check("rst_mem_read", {31'd0, mem_rd}, 32'd0);
    check("rst_mem_write", {31'd0, mem_wr}, 32'd0);
    check("rst_mem_address", {26'd0, mem_addr}, 32'd0);
    check("rst_mem_writedata", mem_wdata, 32'd0);
    check("rst_readdata", {24'd0, rdata}, 32'd0);
    rd = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // reset in the middle of a refill
    rd = 1'b1;
    addr = 8'h10;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("midrst_mem_read_before", {31'd0, mem_rd}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_mem_read", {31'd0, mem_rd}, 32'd0);
    check("midrst_busywait", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rd = 1'b0;
    rst_n = 1'b1;
    check("midrst_no_transfer", rd_log_q.size(), 32'd0);
    rd_log_q.delete();
    @(posedge clk);
    #1;
    access(1'b1, 1'b0, 8'h10, 8'h00, st, got);
    check("miss_0x10_stall", st, 32'd8);
    check("miss_0x10_data", {24'd0, got}, 32'h10);
    check_rd_log("miss_0x10_block", 6'h04);

    // cold read miss
    access(1'b1, 1'b0, 8'h25, 8'h00, st, got);
    check("cold_0x25_stall", st, 32'd8);
    check("cold_0x25_data", {24'd0, got}, 32'hBB);
    check_rd_log("cold_0x25_block", 6'h09);

    // hit vectors on the filled lines (index 1 and index 4)
    vecs[0] = '{1'b1, 1'b0, 8'h24, 8'h00, 1'b0, 1'b1, 8'hAA};
    vecs[1] = '{1'b1, 1'b0, 8'h27, 8'h00, 1'b0, 1'b1, 8'hDD};
    vecs[2] = '{1'b0, 1'b1, 8'h26, 8'h5E, 1'b0, 1'b0, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 8'h26, 8'h00, 1'b0, 1'b1, 8'h5E};
    vecs[4] = '{1'b1, 1'b1, 8'h25, 8'hFF, 1'b0, 1'b1, 8'hBB};
    vecs[5] = '{1'b1, 1'b0, 8'h25, 8'h00, 1'b0, 1'b1, 8'hBB};
    vecs[6] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b1, 8'h10};
    vecs[7] = '{1'b1, 1'b0, 8'h13, 8'h00, 1'b0, 1'b1, 8'h13};
    vecs[8] = '{1'b0, 1'b0, 8'h24, 8'h00, 1'b0, 1'b1, 8'h00};
    for (int i = 0; i < 9; i++) begin
      rd = vecs[i].r;
      wr = vecs[i].w;
      addr = vecs[i].a;
      wdata = vecs[i].d;
      @(negedge clk);
      check($sformatf("vec%0d_busywait", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
      if (vecs[i].chk_data)
        check($sformatf("vec%0d_readdata", i), {24'd0, rdata}, {24'd0, vecs[i].exp_data});
      @(posedge clk);
      #1;
    end
    rd = 1'b0;
    wr = 1'b0;

    // dirty eviction: index 1, new tag 5
    access(1'b1, 1'b0, 8'hA6, 8'h00, st, got);
    check("evict_0xA6_stall", st, 32'd14);
    check("evict_0xA6_data", {24'd0, got}, 32'h33);
    check_wr_log("evict_0xA6_wb", 6'h09, 32'hDD5EBBAA);
    check_rd_log("evict_0xA6_block", 6'h29);

    // write miss on a clean line, then evict it to observe dirty data
    access(1'b0, 1'b1, 8'h43, 8'h77, st, got);
    check("wmiss_0x43_stall", st, 32'd8);
    check_rd_log("wmiss_0x43_block", 6'h10);
    access(1'b1, 1'b0, 8'h43, 8'h00, st, got);
    check("wmiss_0x43_stall_after", st, 32'd0);
    check("wmiss_0x43_data", {24'd0, got}, 32'h77);
    access(1'b1, 1'b0, 8'h40, 8'h00, st, got);
    check("wmiss_0x40_data", {24'd0, got}, 32'h55);
    access(1'b1, 1'b0, 8'h03, 8'h00, st, got);
    check("evict_0x03_stall", st, 32'd14);
    check("evict_0x03_data", {24'd0, got}, 32'h03);
    check_wr_log("evict_0x03_wb", 6'h10, 32'h77776655);
    check_rd_log("evict_0x03_block", 6'h00);

    // shortest memory latency, clean line replaced
    lat = 1;
    access(1'b1, 1'b0, 8'h84, 8'h00, st, got);
    check("lat1_0x84_stall", st, 32'd4);
    check("lat1_0x84_data", {24'd0, got}, 32'hA0);
    check_rd_log("lat1_0x84_block", 6'h21);

    check("no_stray_writebacks", wr_addr_q.size(), 32'd0);
    check("mem_rd_wr_overlap", overlap, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
